mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single data-memory port of `memory_manager` between two requesters: the core load/store path (requester C) and the program/stack loader DMA (requester D). Accepts requests over valid/ready, issues exactly one registered memory operation per grant, and returns a one-cycle response pulse to the granted requester. C has fixed priority, and a starvation counter guarantees D a grant after a bounded wait. The block sits between the execute stage and `memory_manager`'s `op`/`addr`/`write_data`/`read_data` pins.

## Interface
- `ADDR_W`, 16, address width (matches `memory_manager` `addr`)
- `DATA_W`, 16, data width
- `STARVE_LIMIT`, 4, consecutive lost arbitrations after which D wins (range 1..15)

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `c_req_valid`  in  1  C request present
- `c_req_ready`  out  1  C request accepted this cycle
- `c_req_we`  in  1  1 = write, 0 = read
- `c_req_addr`  in  ADDR_W  C address
- `c_req_wdata`  in  DATA_W  C write data
- `c_rsp_valid`  out  1  one-cycle response pulse to C
- `c_rsp_rdata`  out  DATA_W  read data for C (0 for writes)
- `d_req_valid`, `d_req_ready`, `d_req_we`, `d_req_addr`, `d_req_wdata`, `d_rsp_valid`, `d_rsp_rdata`: same as the C ports, for D
- `mem_op`  out  2  `MEM_READ`/`MEM_WRITE` from `instruction_set`; 2'b00 = no operation
- `mem_addr`  out  ADDR_W  to `memory_manager.addr`
- `mem_wdata`  out  DATA_W  to `memory_manager.write_data`
- `mem_rdata`  in  DATA_W  from `memory_manager.read_data` (combinational)
- `busy`  out  1  high in ISSUE
- `grant_id`  out  1  owner of the current/last grant (0 = C, 1 = D)

## Operation
- FSM with two states, IDLE and ISSUE. Reset enters IDLE.
- **IDLE**
  - Ready is combinational and asserted only in IDLE. At most one of `c_req_ready`/`d_req_ready` is high in any cycle.
  - Winner selection:
    - D wins if `d_req_valid` and (`!c_req_valid` or `starve_cnt == STARVE_LIMIT`).
    - Otherwise C wins if `c_req_valid`.
  - On a handshake (valid & ready):
    - Register `we`, `addr`, `wdata` and the winner into `mem_op`/`mem_addr`/`mem_wdata`/`grant_id`.
    - Go to ISSUE.
- **ISSUE**
  - `mem_op` = `MEM_WRITE` if `we`, else `MEM_READ`, for exactly one cycle.
  - At the end of the cycle:
    - On a read, capture `mem_rdata` into the winner's rsp_rdata register.
    - On a write, clear that register to 0.
    - Set the winner's rsp_valid flop.
    - Return to IDLE, with `mem_op` = 2'b00.
- **`starve_cnt`** (4 bit)
  - Clears on a D grant.
  - Increments (saturating at `STARVE_LIMIT`) on each C grant taken while `d_req_valid` = 1.
  - Otherwise holds.
- **Request stability:** requester fields must stay stable while valid is high and ready is low. The arbiter samples fields only on a handshake.
- **Response data:** `rsp_rdata` holds its value until the next response to the same requester.
- `mem_op` is never anything but 2'b00 outside ISSUE.

## Timing
- Reset values, with the clock running or stopped:
  - FSM = IDLE
  - `mem_op` = 2'b00, `mem_addr` = 0, `mem_wdata` = 0
  - `c/d_rsp_valid` = 0, `c/d_rsp_rdata` = 0
  - `busy` = 0, `grant_id` = 0, `starve_cnt` = 0
- Handshake in cycle N → `mem_op` valid in N+1 (write commits at the end of N+1) → `rsp_valid` high in N+2 only.
- Throughput: one grant every 2 cycles. A new handshake may occur in the same cycle as `rsp_valid`.
- Read-after-write to the same address, back to back, returns the new data: the write commits in N+1, and the read issues in N+3.
- **Reset asserted in ISSUE:**
  - The operation is abandoned and `mem_op` drops to 2'b00 asynchronously.
  - No `rsp_valid` is produced.
  - A write whose clock edge coincides with reset assertion is not guaranteed.
- **Reset released:** the first handshake is possible on the first rising edge after release.
- **Simultaneous valid with `starve_cnt` < limit:** C wins.
- **Simultaneous valid at the limit:** D wins, then the counter clears.

## Test plan
- **Reset:** drive `reset` = 0 mid-ISSUE of a write to 0x0010 → `mem_op` is 2'b00 immediately, no `rsp_valid`, all outputs at reset values.
- **C write then read:**
  - C writes 0xBEEF to 0x0004 → `c_rsp_valid` at N+2 with rdata 0.
  - C then reads 0x0004 → `c_rsp_rdata` = 0xBEEF, `grant_id` = 0.
- **D alone:** D reads 0x0020 (preloaded 0x1234) → `d_rsp_valid` at N+2 with 0x1234, `c_rsp_valid` stays 0.
- **Starvation:** C and D valid continuously, `STARVE_LIMIT` = 4 → grant order C,C,C,C,D,C,C,C,C,D; exactly one ready per IDLE cycle.
- **D-only vs simultaneous:** C idle, D valid → D granted at `starve_cnt` 0. C and D valid together at count 2 → C granted and the count becomes 3.
- **Throughput:** 8 back-to-back C reads → handshakes every 2 cycles, and `rsp_valid` and ready coincide in the same cycle.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the two requesters (C core path, D loader DMA),
// the arbiter, and the memory_manager data port.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              c_req_valid;
    logic              c_req_ready;
    logic              c_req_we;
    logic [ADDR_W-1:0] c_req_addr;
    logic [DATA_W-1:0] c_req_wdata;
    logic              c_rsp_valid;
    logic [DATA_W-1:0] c_rsp_rdata;

    logic              d_req_valid;
    logic              d_req_ready;
    logic              d_req_we;
    logic [ADDR_W-1:0] d_req_addr;
    logic [DATA_W-1:0] d_req_wdata;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rsp_rdata;

    logic [1:0]        mem_op;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  c_req_valid, c_req_we, c_req_addr, c_req_wdata,
        output c_req_ready, c_rsp_valid, c_rsp_rdata,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        output d_req_ready, d_rsp_valid, d_rsp_rdata,
        output mem_op, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester / memory side
    modport master (
        output c_req_valid, c_req_we, c_req_addr, c_req_wdata,
        input  c_req_ready, c_rsp_valid, c_rsp_rdata,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata,
        input  mem_op, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single data-memory port. C has fixed priority;
// a starvation counter forces a D grant after STARVE_LIMIT consecutive losses.
// One registered memory op per grant, one-cycle response pulse two cycles
// after the handshake.
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus,
    output logic              busy,
    output logic              grant_id
);
    // Encodings of the instruction_set memory opcodes
    localparam logic [1:0] MEM_NOP   = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;
    localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state, state_nxt;
    logic              c_win, d_win;
    logic [3:0]        starve_cnt;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              grant_q;
    logic              c_rsp_valid_q, d_rsp_valid_q;
    logic [DATA_W-1:0] c_rdata_q, d_rdata_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Winner selection, ready generation and next state; ready only in IDLE
    always_comb begin
        state_nxt = state;
        c_win     = 1'b0;
        d_win     = 1'b0;
        case (state)
            IDLE: begin
                d_win = bus.d_req_valid && (!bus.c_req_valid || starve_cnt == LIMIT);
                c_win = bus.c_req_valid && !d_win;
                if (c_win || d_win) state_nxt = ISSUE;
            end
            ISSUE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the winning request on handshake, finish it in ISSUE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q          <= MEM_NOP;
            addr_q        <= '0;
            wdata_q       <= '0;
            grant_q       <= 1'b0;
            c_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;
            c_rdata_q     <= '0;
            d_rdata_q     <= '0;
        end else begin
            op_q          <= MEM_NOP;
            c_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;
            if (state == IDLE && d_win) begin
                op_q    <= bus.d_req_we ? MEM_WRITE : MEM_READ;
                addr_q  <= bus.d_req_addr;
                wdata_q <= bus.d_req_wdata;
                grant_q <= 1'b1;
            end else if (state == IDLE && c_win) begin
                op_q    <= bus.c_req_we ? MEM_WRITE : MEM_READ;
                addr_q  <= bus.c_req_addr;
                wdata_q <= bus.c_req_wdata;
                grant_q <= 1'b0;
            end
            if (state == ISSUE) begin
                // Writes return zero so a stale read value never leaks through
                if (grant_q) begin
                    d_rsp_valid_q <= 1'b1;
                    d_rdata_q     <= (op_q == MEM_WRITE) ? '0 : bus.mem_rdata;
                end else begin
                    c_rsp_valid_q <= 1'b1;
                    c_rdata_q     <= (op_q == MEM_WRITE) ? '0 : bus.mem_rdata;
                end
            end
        end
    end

    // Starvation counter: cleared by a D grant, counts C grants that D lost
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (d_win)
                starve_cnt <= '0;
            else if (c_win && bus.d_req_valid && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign bus.c_req_ready = c_win;
    assign bus.d_req_ready = d_win;
    assign bus.c_rsp_valid = c_rsp_valid_q;
    assign bus.d_rsp_valid = d_rsp_valid_q;
    assign bus.c_rsp_rdata = c_rdata_q;
    assign bus.d_rsp_rdata = d_rdata_q;
    assign bus.mem_op      = op_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign busy            = (state == ISSUE);
    assign grant_id        = grant_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed transactions, reset-in-ISSUE, starvation
// ordering, throughput and a randomized two-requester mix checked against a
// rule-level reference model.
module tb_mem_port_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy, grant_id;
    logic preload = 1'b1;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(LIMIT)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    // Memory behind the port: combinational read, write at the clock edge
    logic [15:0] mem_arr [0:255];
    assign bus.mem_rdata = mem_arr[bus.mem_addr[7:0]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= (i == 32) ? 16'h1234 : 16'h0000;
        end else if (bus.mem_op == 2'b10) begin
            mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
    end

    // Reference model state
    logic [15:0] ref_mem [0:255];
    bit          m_idle;
    int          m_loss;
    bit          c_pend, d_pend;
    bit          i_who, i_we;
    logic [15:0] i_addr, i_wd;
    bit          rsp_due, rsp_who;
    logic [15:0] rsp_data, hold_c, hold_d;
    bit          grants[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mem_op"}, 32'(bus.mem_op), 0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
        check({tag, "_c_rsp_valid"}, 32'(bus.c_rsp_valid), 0);
        check({tag, "_d_rsp_valid"}, 32'(bus.d_rsp_valid), 0);
        check({tag, "_c_rsp_rdata"}, 32'(bus.c_rsp_rdata), 0);
        check({tag, "_d_rsp_rdata"}, 32'(bus.d_rsp_rdata), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_grant_id"}, 32'(grant_id), 0);
    endtask

    task automatic drive_idle();
        bus.c_req_valid = 0; bus.c_req_we = 0; bus.c_req_addr = 0; bus.c_req_wdata = 0;
        bus.d_req_valid = 0; bus.d_req_we = 0; bus.d_req_addr = 0; bus.d_req_wdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0;
        drive_idle();
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        reset = 1;
        m_idle = 1; m_loss = 0; c_pend = 0; d_pend = 0;
        rsp_due = 0; hold_c = 0; hold_d = 0;
        grants.delete();
    endtask

    // Single transaction from one requester, with the other idle
    task automatic txn(input bit is_d, input bit we, input logic [15:0] a,
                       input logic [15:0] wd, input string tag);
        int n = 0;
        logic [15:0] exp_rd;
        @(negedge clk);
        if (is_d) begin
            bus.d_req_valid = 1; bus.d_req_we = we; bus.d_req_addr = a; bus.d_req_wdata = wd;
        end else begin
            bus.c_req_valid = 1; bus.c_req_we = we; bus.c_req_addr = a; bus.c_req_wdata = wd;
        end
        #1;
        while (!(is_d ? bus.d_req_ready : bus.c_req_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check({tag, "_ready"}, 32'(is_d ? bus.d_req_ready : bus.c_req_ready), 1);
        @(negedge clk);
        drive_idle();
        #1;
        check({tag, "_mem_op"}, 32'(bus.mem_op), we ? 2 : 1);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(a));
        if (we) check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'(wd));
        check({tag, "_busy"}, 32'(busy), 1);
        check({tag, "_grant_id"}, 32'(grant_id), 32'(is_d));
        exp_rd = we ? 16'h0 : ref_mem[a[7:0]];
        if (we) ref_mem[a[7:0]] = wd;
        @(negedge clk); #1;
        check({tag, "_rsp_valid"}, 32'(is_d ? bus.d_rsp_valid : bus.c_rsp_valid), 1);
        check({tag, "_other_rsp"}, 32'(is_d ? bus.c_rsp_valid : bus.d_rsp_valid), 0);
        check({tag, "_rdata"}, 32'(is_d ? bus.d_rsp_rdata : bus.c_rsp_rdata), 32'(exp_rd));
        check({tag, "_op_idle"}, 32'(bus.mem_op), 0);
        @(negedge clk); #1;
        check({tag, "_pulse_end"}, 32'(is_d ? bus.d_rsp_valid : bus.c_rsp_valid), 0);
    endtask

    // Cycle-by-cycle mix: requests arrive with the given percent probability,
    // are held stable until accepted, and every cycle is compared to the model.
    task automatic run_mix(input int ncyc, input int pc, input int pd, input string tag);
        bit c_w, d_w;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            if (!c_pend && $urandom_range(99) < pc) begin
                c_pend = 1;
                bus.c_req_we = 1'($urandom); bus.c_req_addr = 16'($urandom_range(31));
                bus.c_req_wdata = 16'($urandom);
            end
            if (!d_pend && $urandom_range(99) < pd) begin
                d_pend = 1;
                bus.d_req_we = 1'($urandom); bus.d_req_addr = 16'($urandom_range(31));
                bus.d_req_wdata = 16'($urandom);
            end
            bus.c_req_valid = c_pend;
            bus.d_req_valid = d_pend;
            #1;
            if (rsp_due) begin
                if (rsp_who) hold_d = rsp_data; else hold_c = rsp_data;
            end
            check({tag, "_c_rsp_valid"}, 32'(bus.c_rsp_valid), 32'(rsp_due && !rsp_who));
            check({tag, "_d_rsp_valid"}, 32'(bus.d_rsp_valid), 32'(rsp_due && rsp_who));
            check({tag, "_c_rdata"}, 32'(bus.c_rsp_rdata), 32'(hold_c));
            check({tag, "_d_rdata"}, 32'(bus.d_rsp_rdata), 32'(hold_d));
            rsp_due = 0;
            if (m_idle) begin
                d_w = d_pend && (!c_pend || m_loss == LIMIT);
                c_w = c_pend && !d_w;
                check({tag, "_c_ready"}, 32'(bus.c_req_ready), 32'(c_w));
                check({tag, "_d_ready"}, 32'(bus.d_req_ready), 32'(d_w));
                check({tag, "_idle_op"}, 32'(bus.mem_op), 0);
                check({tag, "_idle_busy"}, 32'(busy), 0);
                if (c_w || d_w) begin
                    i_who  = d_w;
                    i_we   = d_w ? bus.d_req_we : bus.c_req_we;
                    i_addr = d_w ? bus.d_req_addr : bus.c_req_addr;
                    i_wd   = d_w ? bus.d_req_wdata : bus.c_req_wdata;
                    grants.push_back(d_w);
                    if (d_w) m_loss = 0;
                    else if (d_pend && m_loss < LIMIT) m_loss++;
                    if (d_w) d_pend = 0; else c_pend = 0;
                    m_idle = 0;
                end
            end else begin
                check({tag, "_ready_in_issue"}, 32'({bus.c_req_ready, bus.d_req_ready}), 0);
                check({tag, "_mem_op"}, 32'(bus.mem_op), i_we ? 2 : 1);
                check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(i_addr));
                if (i_we) check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'(i_wd));
                check({tag, "_grant_id"}, 32'(grant_id), 32'(i_who));
                check({tag, "_busy"}, 32'(busy), 1);
                rsp_due  = 1;
                rsp_who  = i_who;
                rsp_data = i_we ? 16'h0 : ref_mem[i_addr[7:0]];
                if (i_we) ref_mem[i_addr[7:0]] = i_wd;
                m_idle = 1;
            end
        end
        // Let a handshake taken on the final edge finish, keeping the model in step
        @(negedge clk);
        drive_idle();
        c_pend = 0; d_pend = 0;
        if (!m_idle && i_we) ref_mem[i_addr[7:0]] = i_wd;
        m_idle = 1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int cnt;
        int exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        for (int i = 0; i < 256; i++) ref_mem[i] = (i == 32) ? 16'h1234 : 16'h0000;
        drive_idle();

        // Reset values while held in reset
        @(negedge clk); #1;
        check_reset_vals("por");
        @(negedge clk);
        preload = 0;
        reset = 1;

        // Directed transactions
        txn(0, 1, 16'h0004, 16'hBEEF, "c_wr");
        txn(0, 0, 16'h0004, 16'h0000, "c_rd");
        txn(1, 0, 16'h0020, 16'h0000, "d_rd");

        // Reset asserted in the middle of an ISSUE write
        @(negedge clk);
        bus.c_req_valid = 1; bus.c_req_we = 1; bus.c_req_addr = 16'h0010; bus.c_req_wdata = 16'hAAAA;
        #1;
        check("rst_issue_ready", 32'(bus.c_req_ready), 1);
        @(negedge clk);
        drive_idle();
        #1;
        check("rst_issue_op", 32'(bus.mem_op), 2);
        reset = 0;
        #1;
        check_reset_vals("rst_issue");
        @(negedge clk); #1;
        check("rst_issue_no_rsp", 32'(bus.c_rsp_valid), 0);
        reset = 1;
        @(negedge clk); #1;
        check("rst_rel_no_rsp", 32'(bus.c_rsp_valid), 0);
        check("rst_rel_op", 32'(bus.mem_op), 0);

        // Starvation ordering with both requesters always valid
        do_reset();
        run_mix(40, 100, 100, "starve");
        check("starve_ngrants", 32'(grants.size() >= 10), 1);
        for (int i = 0; i < 10 && i < grants.size(); i++)
            check($sformatf("starve_grant%0d", i), 32'(grants[i]), 32'(exp_order[i]));

        // Back-to-back C traffic: one grant every two cycles
        do_reset();
        run_mix(16, 100, 0, "thru");
        cnt = grants.size();
        check("thru_grants", 32'(cnt), 8);

        // Randomized contention
        do_reset();
        run_mix(600, 50, 50, "mix");
        do_reset();
        run_mix(400, 80, 30, "mix2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
